// File: rtl/alu_pkg.sv
// Shared definitions for the RV32 integer ALU execute stage: function codes,
// funct7 encodings and R-type instruction field positions.
package alu_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_SLL     = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_SLTU    = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SRL     = 4'd6,
    ALU_SRA     = 4'd7,
    ALU_OR      = 4'd8,
    ALU_AND     = 4'd9,
    ALU_INVALID = 4'd15
  } alu_funct_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // R-type field boundaries within the 32-bit instruction word
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;
  localparam int RS2_MSB    = 24;
  localparam int RS2_LSB    = 20;
  localparam int RS1_MSB    = 19;
  localparam int RS1_LSB    = 15;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;

endpackage

// File: rtl/alu_datapath.sv
// Combinational decode of funct7/funct3 into an ALU function code, and the
// single-cycle ALU that evaluates it on operands x and y.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [31:0]                instr,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [N-1:0]               result
);

  localparam int SHW = $clog2(N);

  logic [6:0]     funct7;
  logic [2:0]     funct3;
  logic [SHW-1:0] shamt;
  logic           slt_bit;
  logic           sltu_bit;
  alu_funct_e     funct_d;

  // Register specifiers and opcode belong to other stages
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[RS2_MSB:RS1_LSB], instr[FUNCT3_LSB-1:0]};

  assign funct7   = instr[FUNCT7_MSB:FUNCT7_LSB];
  assign funct3   = instr[FUNCT3_MSB:FUNCT3_LSB];
  assign shamt    = y[SHW-1:0];
  assign slt_bit  = $signed(x) < $signed(y);
  assign sltu_bit = x < y;

  always_comb begin
    funct_d = ALU_INVALID;
    case (funct7)
      F7_BASE: begin
        case (funct3)
          3'b000:  funct_d = ALU_ADD;
          3'b001:  funct_d = ALU_SLL;
          3'b010:  funct_d = ALU_SLT;
          3'b011:  funct_d = ALU_SLTU;
          3'b100:  funct_d = ALU_XOR;
          3'b101:  funct_d = ALU_SRL;
          3'b110:  funct_d = ALU_OR;
          default: funct_d = ALU_AND;
        endcase
      end
      F7_ALT: begin
        case (funct3)
          3'b000:  funct_d = ALU_SUB;
          3'b101:  funct_d = ALU_SRA;
          default: funct_d = ALU_INVALID;
        endcase
      end
      default: funct_d = ALU_INVALID;
    endcase
  end

  assign alu_funct = funct_d;

  // Unused and invalid codes produce 0 so the zero flag reads as set
  always_comb begin
    result = '0;
    case (funct_d)
      ALU_ADD:  result = x + y;
      ALU_SUB:  result = x - y;
      ALU_SLL:  result = x << shamt;
      ALU_SLT:  result = {{(N-1){1'b0}}, slt_bit};
      ALU_SLTU: result = {{(N-1){1'b0}}, sltu_bit};
      ALU_XOR:  result = x ^ y;
      ALU_SRL:  result = x >> shamt;
      ALU_SRA:  result = $unsigned($signed(x) >>> shamt);
      ALU_OR:   result = x | y;
      ALU_AND:  result = x & y;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: combinational datapath followed by a result register
// with zero and illegal-instruction flags.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [31:0]                instr,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  output logic [ALU_FUNCT_WIDTH-1:0] alu_funct,
  output logic [N-1:0]               z,
  output logic                       zero,
  output logic                       illegal
);

  logic [N-1:0] result;

  alu_datapath #(.N(N)) u_datapath (
    .instr     (instr),
    .x         (x),
    .y         (y),
    .alu_funct (alu_funct),
    .result    (result)
  );

  // ena is a plain load enable: no back-pressure, the result is captured on
  // every rising edge where ena=1 and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z       <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else if (ena) begin
      z       <= result;
      zero    <= (result == '0);
      illegal <= (alu_funct == ALU_INVALID);
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed vectors.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] instr;
  logic [31:0] x;
  logic [31:0] y;
  logic [3:0]  alu_funct;
  logic [31:0] z;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_unit #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .instr     (instr),
    .x         (x),
    .y         (y),
    .alu_funct (alu_funct),
    .z         (z),
    .zero      (zero),
    .illegal   (illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Present an op at the falling edge, check the decode, load it on the
  // next rising edge and release ena 1 ns later.
  task automatic do_op(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] exp_funct, input string tag);
    @(negedge clk);
    instr = mk_instr(f7, f3);
    x     = a;
    y     = b;
    ena   = 1'b1;
    #1;
    check({tag, "_funct"}, {28'd0, alu_funct}, {28'd0, exp_funct});
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] ez,
                           input logic ezero, input logic eill);
    check({tag, "_z"},       z,               ez);
    check({tag, "_zero"},    {31'd0, zero},    {31'd0, ezero});
    check({tag, "_illegal"}, {31'd0, illegal}, {31'd0, eill});
  endtask

  localparam logic [6:0] B7 = 7'b0000000;
  localparam logic [6:0] A7 = 7'b0100000;

  initial begin
    rst   = 1'b1;
    ena   = 1'b1;
    instr = mk_instr(B7, 3'b000);
    x     = 32'd5;
    y     = 32'd7;
    // ena ignored while reset is held across edges
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b0;

    do_op(B7, 3'b000, 32'd5, 32'd7, 4'd0, "add");
    check_out("add", 32'd12, 1'b0, 1'b0);
    do_op(A7, 3'b000, 32'd3, 32'd3, 4'd1, "sub_eq");
    check_out("sub_eq", 32'd0, 1'b1, 1'b0);
    do_op(A7, 3'b000, 32'd0, 32'd1, 4'd1, "sub_wrap");
    check_out("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);

    do_op(B7, 3'b010, 32'hFFFF_FFFF, 32'd1, 4'd3, "slt_neg");
    check("slt_neg_z", z, 32'd1);
    do_op(B7, 3'b011, 32'hFFFF_FFFF, 32'd1, 4'd4, "sltu_big");
    check("sltu_big_z", z, 32'd0);
    do_op(B7, 3'b010, 32'd1, 32'hFFFF_FFFF, 4'd3, "slt_pos");
    check("slt_pos_z", z, 32'd0);
    do_op(B7, 3'b011, 32'd1, 32'hFFFF_FFFF, 4'd4, "sltu_small");
    check("sltu_small_z", z, 32'd1);

    do_op(A7, 3'b101, 32'h8000_0000, 32'h0000_0024, 4'd7, "sra");
    check("sra_z", z, 32'hF800_0000);
    do_op(B7, 3'b101, 32'h8000_0000, 32'h0000_0024, 4'd6, "srl");
    check("srl_z", z, 32'h0800_0000);
    do_op(B7, 3'b001, 32'd1, 32'd31, 4'd2, "sll31");
    check("sll31_z", z, 32'h8000_0000);
    do_op(B7, 3'b001, 32'd1, 32'hFFFF_FFE1, 4'd2, "sll_mask");
    check("sll_mask_z", z, 32'd2);

    do_op(B7, 3'b100, 32'hF0F0_1234, 32'h0FF0_00FF, 4'd5, "xor");
    check("xor_z", z, 32'hFF00_12CB);
    do_op(B7, 3'b110, 32'hF0F0_1234, 32'h0FF0_00FF, 4'd8, "or");
    check("or_z", z, 32'hFFF0_12FF);
    do_op(B7, 3'b111, 32'hF0F0_1234, 32'h0FF0_00FF, 4'd9, "and");
    check("and_z", z, 32'h00F0_0034);

    do_op(A7, 3'b111, 32'd5, 32'd7, 4'd15, "ill_alt");
    check_out("ill_alt", 32'd0, 1'b1, 1'b1);
    do_op(7'b0000001, 3'b000, 32'd5, 32'd7, 4'd15, "ill_f7");
    check_out("ill_f7", 32'd0, 1'b1, 1'b1);

    // reset between edges clears flags without a clock
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_async_ill", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_op(B7, 3'b000, 32'd5, 32'd7, 4'd0, "add_after_rst");
    check_out("add_after_rst", 32'd12, 1'b0, 1'b0);

    // hold with ena low while inputs change
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr = mk_instr(A7, 3'b000);
      x     = $urandom_range(100, 1000);
      y     = 32'd3 + i;
    end
    @(posedge clk);
    #1;
    check_out("hold", 32'd12, 1'b0, 1'b0);

    // reset mid-operation discards a pending load
    @(negedge clk);
    instr = mk_instr(B7, 3'b110);
    x     = 32'h0000_00F0;
    y     = 32'h0000_000F;
    ena   = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_async_z", 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_pending", 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ena = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
